wb_arb2: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter.
- Lets the J1 code bus (master 0) and the J1 data bus (master 1) share one single-ported unified memory slave.
- Sits between j1_wb and the memory, replacing the separate ROM/RAM paths.
- Grants are held for a whole bus cycle. Grants are fair round-robin, or fixed priority if configured. A watchdog ends any slave access that stalls.

---
 rtl/wb_arb2_if.sv | 39 +++
 rtl/wb_arb2.sv | 98 +++++++++
 tb/tb_wb_arb2.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb2_if.sv
// Signal bundle around the two-master Wishbone arbiter: the J1 code/data master ports and the memory port.
// slave = the arbiter's own view; master = the J1 buses and memory that surround it.
interface wb_arb2_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;

    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;

    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_arb2.sv
// Two-master, one-slave Wishbone classic arbiter sharing the unified J1 memory between code and data buses.
// Grants last a whole bus cycle; round-robin or fixed priority; a watchdog ends stalled strobes with err.
//
// state | meaning
// IDLE  | no grant, all slave outputs low
// G0    | master 0 (J1 code bus) owns the slave
// G1    | master 1 (J1 data bus) owns the slave
module wb_arb2 #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    wb_arb2_if.slave   bus,
    output logic [1:0] gnt_o
);
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;     // 1 = master 1 held the most recent grant
    logic [CW-1:0] wdog_q, wdog_d;
    logic          own0, own1;
    logic          stb_raw, wd_fire;
    logic [AW-1:0] adr_sel;
    logic [DW-1:0] dat_sel;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin : arbitrate
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    if ((FIXED_PRIO != 0) || last_q) state_d = G0;
                    else                             state_d = G1;
                end else if (bus.m0_cyc_i) begin
                    state_d = G0;
                end else if (bus.m1_cyc_i) begin
                    state_d = G1;
                end
            end
            G0:      if (!bus.m0_cyc_i) state_d = IDLE;
            G1:      if (!bus.m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == G0)      last_d = 1'b0;
        else if (state_d == G1) last_d = 1'b1;
    end

    always_comb begin : datapath
        own0    = (state_q == G0);
        own1    = (state_q == G1);
        stb_raw = (own0 & bus.m0_stb_i) | (own1 & bus.m1_stb_i);

        // An ack landing on the terminal count wins over the timeout.
        wd_fire = (TIMEOUT > 0) && stb_raw && !bus.s_ack_i && (wdog_q == WD_LIMIT);
        wdog_d  = wdog_q + 1'b1;
        if ((TIMEOUT == 0) || !stb_raw || bus.s_ack_i || wd_fire) wdog_d = '0;

        adr_sel = ({AW{own0}} & bus.m0_adr_i) | ({AW{own1}} & bus.m1_adr_i);
        dat_sel = ({DW{own0}} & bus.m0_dat_i) | ({DW{own1}} & bus.m1_dat_i);

        bus.s_cyc_o = (own0 & bus.m0_cyc_i) | (own1 & bus.m1_cyc_i);
        bus.s_stb_o = stb_raw & ~wd_fire;
        bus.s_we_o  = (own0 & bus.m0_we_i) | (own1 & bus.m1_we_i);
        bus.s_adr_o = adr_sel;
        bus.s_dat_o = dat_sel;

        bus.m0_dat_o = bus.s_dat_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m0_ack_o = own0 & bus.s_ack_i;
        bus.m1_ack_o = own1 & bus.s_ack_i;
        bus.m0_err_o = own0 & wd_fire;
        bus.m1_err_o = own1 & wd_fire;

        gnt_o = {own1, own0};
    end
endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: a round-robin instance with an 8-cycle watchdog and a fixed-priority instance.
module tb_wb_arb2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] gnt_a, gnt_b;
    int         n_chk  = 0;
    int         n_fail = 0;

    wb_arb2_if #(.AW(16), .DW(16)) a ();
    wb_arb2_if #(.AW(16), .DW(16)) b ();

    wb_arb2 #(.AW(16), .DW(16), .FIXED_PRIO(0), .TIMEOUT(8)) u_rr (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .bus       (a.slave),
        .gnt_o     (gnt_a)
    );

    wb_arb2 #(.AW(16), .DW(16), .FIXED_PRIO(1), .TIMEOUT(255)) u_fp (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .bus       (b.slave),
        .gnt_o     (gnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a.m0_cyc_i = 1'b0; a.m0_stb_i = 1'b0; a.m0_we_i = 1'b0;
        a.m0_adr_i = '0;   a.m0_dat_i = '0;
        a.m1_cyc_i = 1'b0; a.m1_stb_i = 1'b0; a.m1_we_i = 1'b0;
        a.m1_adr_i = '0;   a.m1_dat_i = '0;
        a.s_dat_i  = '0;   a.s_ack_i  = 1'b0;
    endtask

    task automatic clear_b();
        b.m0_cyc_i = 1'b0; b.m0_stb_i = 1'b0; b.m0_we_i = 1'b0;
        b.m0_adr_i = '0;   b.m0_dat_i = '0;
        b.m1_cyc_i = 1'b0; b.m1_stb_i = 1'b0; b.m1_we_i = 1'b0;
        b.m1_adr_i = '0;   b.m1_dat_i = '0;
        b.s_dat_i  = '0;   b.s_ack_i  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_a();
        clear_b();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt",   32'(gnt_a), 32'd0);
        chk("rst_scyc",  32'(a.s_cyc_o), 32'd0);
        chk("rst_sstb",  32'(a.s_stb_o), 32'd0);
        chk("rst_term",  32'({a.m0_ack_o, a.m1_ack_o, a.m0_err_o, a.m1_err_o}), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // tie straight after reset: m0 first, one idle cycle, then m1
        a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1; a.m0_adr_i = 16'h0100;
        a.m1_cyc_i = 1'b1; a.m1_stb_i = 1'b1; a.m1_adr_i = 16'h0200;
        #1 chk("tie1_idle", 32'(gnt_a), 32'd0);
        step();
        a.s_ack_i = 1'b1; a.s_dat_i = 16'h1234;
        #1;
        chk("tie1_gnt",    32'(gnt_a), 32'd1);
        chk("tie1_adr",    32'(a.s_adr_o), 32'h0100);
        chk("tie1_m0ack",  32'(a.m0_ack_o), 32'd1);
        chk("tie1_m1ack",  32'(a.m1_ack_o), 32'd0);
        chk("tie1_m1dat",  32'(a.m1_dat_o), 32'h1234);
        step();
        a.m0_cyc_i = 1'b0; a.m0_stb_i = 1'b0; a.s_ack_i = 1'b0;
        #1;
        chk("tie1_hold",   32'(gnt_a), 32'd1);
        chk("tie1_cycoff", 32'(a.s_cyc_o), 32'd0);
        step();
        #1 chk("tie1_gap",  32'(gnt_a), 32'd0);
        step();
        a.s_ack_i = 1'b1;
        #1;
        chk("tie1_m1gnt",  32'(gnt_a), 32'd2);
        chk("tie1_m1adr",  32'(a.s_adr_o), 32'h0200);
        chk("tie1_m1ack2", 32'(a.m1_ack_o), 32'd1);
        chk("tie1_m0ack2", 32'(a.m0_ack_o), 32'd0);
        step();
        a.m1_cyc_i = 1'b0; a.m1_stb_i = 1'b0; a.s_ack_i = 1'b0;
        step();
        #1 chk("tie1_end", 32'(gnt_a), 32'd0);

        // single m0 read of 0x0010 returning 0xBEEF
        a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1; a.m0_we_i = 1'b0; a.m0_adr_i = 16'h0010;
        #1 chk("rd_latency", 32'(gnt_a), 32'd0);
        step();
        a.s_ack_i = 1'b1; a.s_dat_i = 16'hBEEF;
        #1;
        chk("rd_gnt",    32'(gnt_a), 32'd1);
        chk("rd_scyc",   32'(a.s_cyc_o), 32'd1);
        chk("rd_sstb",   32'(a.s_stb_o), 32'd1);
        chk("rd_sadr",   32'(a.s_adr_o), 32'h0010);
        chk("rd_swe",    32'(a.s_we_o), 32'd0);
        chk("rd_m0dat",  32'(a.m0_dat_o), 32'hBEEF);
        chk("rd_m0ack",  32'(a.m0_ack_o), 32'd1);
        chk("rd_m1ack",  32'(a.m1_ack_o), 32'd0);
        step();
        clear_a();
        #1 chk("rd_ackoff", 32'(a.m0_ack_o), 32'd0);
        step();
        #1 chk("rd_idle",   32'(gnt_a), 32'd0);

        // same tie again, m0 was last: m1 goes first, m0 follows
        a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1; a.m0_adr_i = 16'h0100;
        a.m1_cyc_i = 1'b1; a.m1_stb_i = 1'b1; a.m1_adr_i = 16'h0200;
        step();
        a.s_ack_i = 1'b1;
        #1;
        chk("tie2_gnt",   32'(gnt_a), 32'd2);
        chk("tie2_m1ack", 32'(a.m1_ack_o), 32'd1);
        chk("tie2_m0ack", 32'(a.m0_ack_o), 32'd0);
        step();
        a.m1_cyc_i = 1'b0; a.m1_stb_i = 1'b0; a.s_ack_i = 1'b0;
        step();
        step();
        a.s_ack_i = 1'b1;
        #1;
        chk("tie2_m0gnt", 32'(gnt_a), 32'd1);
        chk("tie2_m0ack2", 32'(a.m0_ack_o), 32'd1);
        step();
        clear_a();
        step();

        // m1 4-beat write burst, m0 requests during beat 2
        a.m1_cyc_i = 1'b1; a.m1_stb_i = 1'b1; a.m1_we_i = 1'b1;
        a.m1_adr_i = 16'h4000; a.m1_dat_i = 16'hA000;
        step();
        for (int i = 0; i < 4; i++) begin
            a.m1_adr_i = 16'h4000 + 16'(i);
            a.m1_dat_i = 16'hA000 + 16'(i);
            a.s_ack_i  = 1'b1;
            if (i == 1) begin
                a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1; a.m0_adr_i = 16'h0030;
            end
            #1;
            chk("burst_gnt",   32'(gnt_a), 32'd2);
            chk("burst_adr",   32'(a.s_adr_o), 32'h4000 + 32'(i));
            chk("burst_dat",   32'(a.s_dat_o), 32'hA000 + 32'(i));
            chk("burst_we",    32'(a.s_we_o), 32'd1);
            chk("burst_m1ack", 32'(a.m1_ack_o), 32'd1);
            chk("burst_m0ack", 32'(a.m0_ack_o), 32'd0);
            step();
        end
        a.m1_cyc_i = 1'b0; a.m1_stb_i = 1'b0; a.m1_we_i = 1'b0; a.s_ack_i = 1'b0;
        #1;
        chk("burst_tail",  32'(gnt_a), 32'd2);
        chk("burst_m0wait", 32'(a.m0_ack_o), 32'd0);
        step();
        #1 chk("burst_gap", 32'(gnt_a), 32'd0);
        step();
        #1;
        chk("burst_m0gnt", 32'(gnt_a), 32'd1);
        chk("burst_m0adr", 32'(a.s_adr_o), 32'h0030);
        clear_a();
        step();
        step();

        // watchdog: no ack for 8 cycles -> err, stb cut, grant kept; then ack on the terminal count
        a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1; a.m0_adr_i = 16'h0040;
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wd_stb",   32'(a.s_stb_o), 32'd1);
            chk("wd_noerr", 32'(a.m0_err_o), 32'd0);
            step();
        end
        #1;
        chk("wd_err",    32'(a.m0_err_o), 32'd1);
        chk("wd_stbcut", 32'(a.s_stb_o), 32'd0);
        chk("wd_gnt",    32'(gnt_a), 32'd1);
        chk("wd_noack",  32'(a.m0_ack_o), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wd2_stb",   32'(a.s_stb_o), 32'd1);
            chk("wd2_noerr", 32'(a.m0_err_o), 32'd0);
            step();
        end
        a.s_ack_i = 1'b1;
        #1;
        chk("wd2_ack",   32'(a.m0_ack_o), 32'd1);
        chk("wd2_err",   32'(a.m0_err_o), 32'd0);
        chk("wd2_stb8",  32'(a.s_stb_o), 32'd1);
        step();
        clear_a();
        step();
        step();

        // fixed priority: m0 wins every tie, m1 only gets in while m0 is idle
        b.m0_cyc_i = 1'b1; b.m0_stb_i = 1'b1; b.m0_adr_i = 16'h0050;
        b.m1_cyc_i = 1'b1; b.m1_stb_i = 1'b1; b.m1_adr_i = 16'h0060;
        step();
        b.s_ack_i = 1'b1;
        #1;
        chk("fp1_gnt",   32'(gnt_b), 32'd1);
        chk("fp1_m0ack", 32'(b.m0_ack_o), 32'd1);
        chk("fp1_m1ack", 32'(b.m1_ack_o), 32'd0);
        step();
        b.m0_cyc_i = 1'b0; b.m0_stb_i = 1'b0; b.s_ack_i = 1'b0;
        step();
        b.m0_cyc_i = 1'b1; b.m0_stb_i = 1'b1;
        #1 chk("fp_gap1", 32'(gnt_b), 32'd0);
        step();
        b.s_ack_i = 1'b1;
        #1;
        chk("fp2_gnt",   32'(gnt_b), 32'd1);
        chk("fp2_m0ack", 32'(b.m0_ack_o), 32'd1);
        chk("fp2_m1ack", 32'(b.m1_ack_o), 32'd0);
        step();
        b.m0_cyc_i = 1'b0; b.m0_stb_i = 1'b0; b.s_ack_i = 1'b0;
        step();
        #1 chk("fp_gap2", 32'(gnt_b), 32'd0);
        step();
        b.s_ack_i = 1'b1;
        #1;
        chk("fp_m1gnt", 32'(gnt_b), 32'd2);
        chk("fp_m1ack", 32'(b.m1_ack_o), 32'd1);
        chk("fp_m1adr", 32'(b.s_adr_o), 32'h0060);
        step();
        clear_b();
        step();

        // asynchronous reset in the middle of an m1 access
        a.m1_cyc_i = 1'b1; a.m1_stb_i = 1'b1; a.m1_adr_i = 16'h0070;
        step();
        a.s_ack_i = 1'b1;
        #1;
        chk("ar_gnt",   32'(gnt_a), 32'd2);
        chk("ar_scyc",  32'(a.s_cyc_o), 32'd1);
        chk("ar_m1ack", 32'(a.m1_ack_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt0",  32'(gnt_a), 32'd0);
        chk("ar_scyc0", 32'(a.s_cyc_o), 32'd0);
        chk("ar_sstb0", 32'(a.s_stb_o), 32'd0);
        chk("ar_term0", 32'({a.m0_ack_o, a.m1_ack_o, a.m0_err_o, a.m1_err_o}), 32'd0);
        clear_a();
        step();
        a.m0_cyc_i = 1'b1; a.m0_stb_i = 1'b1;
        a.m1_cyc_i = 1'b1; a.m1_stb_i = 1'b1;
        rst_n = 1'b1;
        #1 chk("ar_idle", 32'(gnt_a), 32'd0);
        step();
        #1 chk("ar_tie",  32'(gnt_a), 32'd1);
        clear_a();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
